// File: rtl/i_mem_loader_if.sv
// rtl/i_mem_loader_if.sv - byte-load stream and fetch port bundle for i_mem_loader
//
// Purpose: groups the boot byte stream (ld_*) and the CPU fetch port (r_*, dout*).
// Ports:
//   ld_data[7:0], ld_valid   byte source -> loader
//   ld_ready                 loader -> byte source
//   r_addr, r_en             fetch request
//   dout, dout_valid         fetched word and its qualifier
// Modports: master = byte source / fetch requester, slave = memory.
interface i_mem_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            ld_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;

    modport master (
        output ld_data, ld_valid, r_addr, r_en,
        input  ld_ready, dout, dout_valid
    );

    modport slave (
        input  ld_data, ld_valid, r_addr, r_en,
        output ld_ready, dout, dout_valid
    );
endinterface

// File: rtl/i_mem_loader.sv
// rtl/i_mem_loader.sv - instruction memory with little-endian byte-stream boot loader
//
// Purpose: assembles BYTES=DATA_WIDTH/8 bytes per word from the byte stream and writes
// the words to consecutive (wrapping) word addresses; a registered fetch port serves the
// core, with same-cycle write data forwarded to a colliding fetch.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_start        start pulse, sampled only in IDLE
//   load_addr         first word address of the session
//   load_len          words to load, 0..2**ADDR_WIDTH
//   load_busy         session in RECV/WRITE
//   load_done         one-cycle pulse at session end
//   bus (slave)       ld_data/ld_valid/ld_ready byte stream, r_addr/r_en/dout/dout_valid fetch
// Parameters: ADDR_WIDTH, DATA_WIDTH, INIT_FILE (preload image name for the tool flow;
//   the array itself is never cleared by reset).
// Configuration macro: I_MEM_OUT_REG_EN adds a second fetch output register (latency 2).
module i_mem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter     INIT_FILE  = "i_ram.ini"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [ADDR_WIDTH:0]   load_len,
    output logic                  load_busy,
    output logic                  load_done,
    i_mem_loader_if.slave         bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    wr_ptr_d    = load_addr;
                    remaining_d = load_len;
                    byte_cnt_d  = '0;
                    state_d     = (load_len == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (bus.ld_valid) begin
                    // Byte k of the word lands in bits [8k+7:8k] (little-endian).
                    for (int k = 0; k < BYTES; k++) begin
                        if (byte_cnt_q == BCW'(k)) begin
                            word_d[8*k +: 8] = bus.ld_data;
                        end
                    end
                    if (byte_cnt_q == BCW'(BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // wr_ptr wraps naturally at ADDR_WIDTH bits.
                wr_ptr_d    = wr_ptr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ld_ready = (state_q == S_RECV);
    assign load_busy    = (state_q == S_RECV) || (state_q == S_WRITE);
    assign load_done    = (state_q == S_DONE);

    // A reset landing on the WRITE cycle aborts the session before the word commits.
    assign mem_we = (state_q == S_WRITE) && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= word_q;
        end
    end

    // Forward the word being written so a colliding fetch never sees stale contents.
    assign rd_word = ((state_q == S_WRITE) && (bus.r_addr == wr_ptr_q)) ? word_q
                                                                        : mem[bus.r_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= bus.r_en;
            if (bus.r_en) begin
                dout_q <= rd_word;
            end
        end
    end

`ifdef I_MEM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] dout2_q;
    logic                  dout_valid2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout2_q       <= '0;
            dout_valid2_q <= 1'b0;
        end else begin
            dout_valid2_q <= dout_valid_q;
            if (dout_valid_q) begin
                dout2_q <= dout_q;
            end
        end
    end

    assign bus.dout       = dout2_q;
    assign bus.dout_valid = dout_valid2_q;
`else
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
`endif

endmodule

// File: tb/tb_i_mem_loader.sv
// tb/tb_i_mem_loader.sv - directed self-checking bench for i_mem_loader
module tb_i_mem_loader;
    logic        clk;
    logic        rst;
    logic        load_start;
    logic [9:0]  load_addr;
    logic [10:0] load_len;
    logic        load_busy;
    logic        load_done;

    int n_tests;
    int n_fail;
    int obs_done;
    int obs_wr;

    logic [7:0] byte_buf [0:2047];

    i_mem_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus ();

    i_mem_loader #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(16),
        .INIT_FILE (""  )
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .load_addr (load_addr),
        .load_len  (load_len),
        .load_busy (load_busy),
        .load_done (load_done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        if (load_done) obs_done++;
        if (load_busy && !bus.ld_ready) obs_wr++;
    endtask

    // Runs a full session with ld_valid held high; bytes come from byte_buf.
    task automatic run_load(input logic [9:0] a, input logic [10:0] len, input int nb);
        int guard;
        obs_done   = 0;
        obs_wr     = 0;
        load_start = 1'b1;
        load_addr  = a;
        load_len   = len;
        tick();
        observe();
        load_start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bus.ld_data  = byte_buf[i];
            bus.ld_valid = 1'b1;
            guard = 0;
            while (!bus.ld_ready && guard < 50) begin
                tick();
                observe();
                guard++;
            end
            if (guard >= 50) check("ld_ready_timeout", 32'd0, 32'd1);
            tick();
            observe();
        end
        bus.ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            observe();
        end
    endtask

    task automatic fetch_chk(input string tag, input logic [9:0] a, input logic [15:0] exp);
        bus.r_en   = 1'b1;
        bus.r_addr = a;
        tick();
        bus.r_en = 1'b0;
`ifdef I_MEM_OUT_REG_EN
        tick();
`endif
        check({tag, "_dout"}, 32'(bus.dout), 32'(exp));
        check({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        load_start   = 1'b0;
        load_addr    = '0;
        load_len     = '0;
        bus.ld_data  = '0;
        bus.ld_valid = 1'b0;
        bus.r_addr   = '0;
        bus.r_en     = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_ld_ready",   32'(bus.ld_ready),   32'd0);
        check("rst_load_busy",  32'(load_busy),      32'd0);
        check("rst_load_done",  32'(load_done),      32'd0);
        check("rst_dout",       32'(bus.dout),       32'd0);
        check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Full-array fill from 0x100: word j = {C0|j[9:8], j[7:0]}
        for (int j = 0; j < 1024; j++) begin
            byte_buf[2*j]   = 8'(j);
            byte_buf[2*j+1] = 8'hC0 | 8'(j >> 8);
        end
        run_load(10'h100, 11'd1024, 2048);
        check("full_done_cnt", 32'(obs_done), 32'd1);
        check("full_wr_cycles", 32'(obs_wr), 32'd1024);
        fetch_chk("full_100", 10'h100, 16'hC000);
        fetch_chk("full_3ff", 10'h3FF, 16'hC2FF);
        fetch_chk("full_0ff", 10'h0FF, 16'hC3FF);

        // Basic load: 0x010 <- 1234, 0x011 <- ABCD
        byte_buf[0] = 8'h34; byte_buf[1] = 8'h12; byte_buf[2] = 8'hCD; byte_buf[3] = 8'hAB;
        run_load(10'h010, 11'd2, 4);
        check("load_done_cnt", 32'(obs_done), 32'd1);
        check("load_wr_cycles", 32'(obs_wr), 32'd2);
        fetch_chk("load_010", 10'h010, 16'h1234);

        // Fetch and hold
        fetch_chk("fetch_011", 10'h011, 16'hABCD);
        tick();
        check("hold_valid", 32'(bus.dout_valid), 32'd0);
        check("hold_dout",  32'(bus.dout),       32'hABCD);

        // Wrap past the top address
        byte_buf[0] = 8'h01; byte_buf[1] = 8'h00; byte_buf[2] = 8'h02; byte_buf[3] = 8'h00;
        run_load(10'h3FF, 11'd2, 4);
        check("wrap_done_cnt", 32'(obs_done), 32'd1);
        fetch_chk("wrap_3ff", 10'h3FF, 16'h0001);
        fetch_chk("wrap_000", 10'h000, 16'h0002);

        // Forwarding: 0x020 holds 1111, then rewritten to BEEF while fetched
        byte_buf[0] = 8'h11; byte_buf[1] = 8'h11;
        run_load(10'h020, 11'd1, 2);
        load_start = 1'b1; load_addr = 10'h020; load_len = 11'd1;
        tick();
        load_start   = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 8'hEF;
        tick();
        bus.ld_data = 8'hBE;
        tick();
        bus.ld_valid = 1'b0;
        check("fwd_write_ready", 32'(bus.ld_ready), 32'd0);
        check("fwd_write_busy",  32'(load_busy),    32'd1);
        bus.r_en = 1'b1; bus.r_addr = 10'h020;
        tick();
        bus.r_en = 1'b0;
`ifdef I_MEM_OUT_REG_EN
        tick();
`endif
        check("fwd_dout",  32'(bus.dout),       32'hBEEF);
        check("fwd_valid", 32'(bus.dout_valid), 32'd1);
        tick();
        tick();
        fetch_chk("fwd_after", 10'h020, 16'hBEEF);

        // Zero-length session
        load_start = 1'b1; load_addr = 10'h010; load_len = 11'd0;
        tick();
        load_start = 1'b0;
        check("len0_done", 32'(load_done), 32'd1);
        check("len0_busy", 32'(load_busy), 32'd0);
        tick();
        check("len0_done_clr", 32'(load_done), 32'd0);
        fetch_chk("len0_mem", 10'h010, 16'h1234);

        // load_start while busy is ignored
        load_start = 1'b1; load_addr = 10'h030; load_len = 11'd1;
        tick();
        load_start = 1'b1; load_addr = 10'h040; load_len = 11'd5;
        bus.ld_valid = 1'b1; bus.ld_data = 8'h78;
        tick();
        load_start  = 1'b0;
        bus.ld_data = 8'h56;
        tick();
        bus.ld_valid = 1'b0;
        tick();
        check("busy_start_done", 32'(load_done), 32'd1);
        tick();
        check("busy_start_idle", 32'(load_busy), 32'd0);
        fetch_chk("busy_start_mem", 10'h030, 16'h5678);

        // Abort by reset mid-session
        byte_buf[0] = 8'hAA; byte_buf[1] = 8'hAA; byte_buf[2] = 8'h55; byte_buf[3] = 8'h55;
        run_load(10'h050, 11'd2, 4);
        obs_done   = 0;
        obs_wr     = 0;
        load_start = 1'b1; load_addr = 10'h050; load_len = 11'd2;
        tick(); observe();
        load_start   = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 8'h11;
        tick(); observe();
        bus.ld_data = 8'h22;
        tick(); observe();
        tick(); observe();
        bus.ld_data = 8'h33;
        tick(); observe();
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        tick(); observe();
        rst = 1'b0;
        check("abort_busy",  32'(load_busy),    32'd0);
        check("abort_ready", 32'(bus.ld_ready), 32'd0);
        tick(); observe();
        tick(); observe();
        check("abort_no_done", 32'(obs_done), 32'd0);
        fetch_chk("abort_w0", 10'h050, 16'h2211);
        fetch_chk("abort_w1", 10'h051, 16'h5555);
        byte_buf[0] = 8'h99; byte_buf[1] = 8'h88;
        run_load(10'h051, 11'd1, 2);
        check("after_abort_done", 32'(obs_done), 32'd1);
        fetch_chk("after_abort_mem", 10'h051, 16'h8899);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
